// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: pipeline hold encodings, bus widths and the hold scheduler state enum.
package tinyriscv_pkg;

  localparam int InstAddrW  = 32;
  localparam int HoldFlagW  = 2;

  localparam logic                 HoldEnable = 1'b1;
  localparam logic                 JumpEnable = 1'b1;

  localparam logic [HoldFlagW-1:0] Pipe_Flow  = 2'b00;
  localparam logic [HoldFlagW-1:0] Pipe_Pause = 2'b01;
  localparam logic [HoldFlagW-1:0] Pipe_Clear = 2'b10;

  localparam int FlushCntW = 3;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    FLUSH  = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    RESUME = 3'd4
  } hold_sched_state_e;

endpackage

// File: rtl/hold_stall_wdt.sv
// Stall watchdog: counts consecutive paused RUN cycles and emits a single registered
// pulse when the count reaches StallLimit, saturating until the pause ends.
module hold_stall_wdt #(
  parameter int StallLimit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pause_i,
  output logic timeout_o
);

  localparam int CntW = $clog2(StallLimit + 1);
  localparam logic [CntW-1:0] Limit   = CntW'(StallLimit);
  localparam logic [CntW-1:0] LimitM1 = CntW'(StallLimit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (!pause_i) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d     = cnt_q + CntW'(1);
      timeout_d = (cnt_q == LimitM1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hold_sched.sv
// Pipeline hold scheduler: stretched post-jump flushes, debug halt/drain/resume handshake.
// Optional stall watchdog enabled by defining PIPE_HOLD_SCHED_WDT_EN.
module pipe_hold_sched
  import tinyriscv_pkg::*;
#(
  parameter int FlushCycles = 1,
  parameter int StallLimit  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 jump_flag_i,
  input  logic [InstAddrW-1:0] jump_addr_i,
  input  logic                 hold_ex_i,
  input  logic                 hold_rib_i,
  input  logic                 hold_clint_i,
  input  logic                 dbg_halt_req_i,
  input  logic                 dbg_resume_req_i,
  output logic [HoldFlagW-1:0] hold_flag_o,
  output logic                 jump_flag_o,
  output logic [InstAddrW-1:0] jump_addr_o,
  output logic                 dbg_halted_o,
  output logic                 stall_timeout_o
);

  localparam logic [FlushCntW-1:0] FlushReload = FlushCntW'(FlushCycles - 1);

  hold_sched_state_e    state_q, state_d;
  logic [FlushCntW-1:0] fcnt_q, fcnt_d;
  logic                 halted_q, halted_d;
  logic [HoldFlagW-1:0] hold_flag;
  logic                 jump_flag;
  logic                 jump_req, clint_req, stall_req;

  assign jump_req  = (jump_flag_i == JumpEnable);
  assign clint_req = (hold_clint_i == HoldEnable);
  assign stall_req = (hold_ex_i == HoldEnable) || (hold_rib_i == HoldEnable);

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hold_flag = Pipe_Flow;
    jump_flag = jump_flag_i;
    unique case (state_q)
      RUN: begin
        if (jump_req || clint_req) hold_flag = Pipe_Clear;
        else if (stall_req)        hold_flag = Pipe_Pause;
        if (jump_req && (FlushCycles > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FlushReload;
        end else if (dbg_halt_req_i && !jump_req && !clint_req) begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        hold_flag = Pipe_Clear;
        if (jump_req) begin
          fcnt_d = FlushReload;
        end else if (fcnt_q <= FlushCntW'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FlushCntW'(1);
        end
      end
      // A jump or interrupt flush while draining is honoured without abandoning the drain.
      DRAIN: begin
        if (jump_req || clint_req) begin
          hold_flag = Pipe_Clear;
        end else begin
          hold_flag = Pipe_Pause;
          if (!dbg_halt_req_i) state_d = RUN;
          else if (!stall_req) state_d = HALTED;
        end
      end
      HALTED: begin
        hold_flag = Pipe_Clear;
        jump_flag = 1'b0;
        if (dbg_resume_req_i && !dbg_halt_req_i) state_d = RESUME;
      end
      RESUME: begin
        hold_flag = Pipe_Clear;
        state_d   = RUN;
      end
      default: begin
        hold_flag = Pipe_Clear;
        state_d   = RUN;
        fcnt_d    = '0;
      end
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      halted_q <= halted_d;
    end
  end

  assign hold_flag_o  = rst_ni ? hold_flag : Pipe_Clear;
  assign jump_flag_o  = rst_ni & jump_flag;
  assign jump_addr_o  = jump_addr_i;
  assign dbg_halted_o = halted_q;

`ifdef PIPE_HOLD_SCHED_WDT_EN
  logic wdt_pause;
  assign wdt_pause = (state_q == RUN) && (hold_flag == Pipe_Pause);

  hold_stall_wdt #(
    .StallLimit(StallLimit)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pause_i  (wdt_pause),
    .timeout_o(stall_timeout_o)
  );
`else
  assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hold_sched.sv
// Directed, table-driven bench for pipe_hold_sched with FlushCycles=3, StallLimit=4.
module tb_pipe_hold_sched;

  localparam int FlushCycles = 3;
  localparam int StallLimit  = 4;

  localparam logic [1:0] F = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] C = 2'b10;

`ifdef PIPE_HOLD_SCHED_WDT_EN
  localparam bit WdtOn = 1'b1;
`else
  localparam bit WdtOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, jump, ex, rib, clint, halt, resume;
  logic [31:0] addr;
  logic [1:0]  hold_flag_o;
  logic        jump_flag_o, dbg_halted_o, stall_timeout_o;
  logic [31:0] jump_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hold_sched #(
    .FlushCycles(FlushCycles),
    .StallLimit (StallLimit)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .jump_flag_i     (jump),
    .jump_addr_i     (addr),
    .hold_ex_i       (ex),
    .hold_rib_i      (rib),
    .hold_clint_i    (clint),
    .dbg_halt_req_i  (halt),
    .dbg_resume_req_i(resume),
    .hold_flag_o     (hold_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .dbg_halted_o    (dbg_halted_o),
    .stall_timeout_o (stall_timeout_o)
  );

  typedef struct {
    logic       r, j, ex, rib, cl, hr, rs;
    logic [1:0] h;
    logic       jo, hd, to;
  } vec_t;

  function automatic vec_t mk(logic r, logic j, logic e, logic b, logic cl, logic hr,
                              logic rs, logic [1:0] h, logic jo, logic hd, logic to);
    vec_t v;
    v.r = r; v.j = j; v.ex = e; v.rib = b; v.cl = cl; v.hr = hr; v.rs = rs;
    v.h = h; v.jo = jo; v.hd = hd; v.to = to;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check mid-cycle, advance.
  task automatic apply(vec_t v, int idx);
    rst_n = v.r; jump = v.j; ex = v.ex; rib = v.rib; clint = v.cl;
    halt = v.hr; resume = v.rs; addr = $urandom;
    #4;
    chk("hold_flag", idx, 32'(hold_flag_o), 32'(v.h));
    chk("jump_flag", idx, 32'(jump_flag_o), 32'(v.jo));
    chk("dbg_halted", idx, 32'(dbg_halted_o), 32'(v.hd));
    chk("stall_timeout", idx, 32'(stall_timeout_o), 32'(v.to));
    chk("jump_addr", idx, jump_addr_o, addr);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    int pulses;
    rst_n = 1'b0; jump = 1'b0; ex = 1'b0; rib = 1'b0; clint = 1'b0;
    halt = 1'b0; resume = 1'b0; addr = '0;
    @(posedge clk);
    #1;

    //                   r  j  ex rib cl hr rs  hold jo hd to
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 0 reset
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 1 jump masked in reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 2
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, C, 1, 0, 0));  // 3 jump -> FLUSH
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 4
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 5
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 6
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, C, 1, 0, 0));  // 7 jump
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, C, 1, 0, 0));  // 8 reload in FLUSH
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 9
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 10
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 11
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, P, 0, 0, 0));  // 12 ex hold
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, C, 0, 0, 0));  // 13 clint wins
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, P, 0, 0, 0));  // 14
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 15
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, P, 0, 0, 0));  // 16 rib hold
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, P, 0, 0, 0));  // 17 halt req -> DRAIN
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, P, 0, 0, 0));  // 18 DRAIN
    tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, C, 1, 0, 0));  // 19 jump in DRAIN
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, P, 0, 0, 0));  // 20 holds drop
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, C, 0, 1, 0));  // 21 HALTED
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, C, 0, 1, 0));  // 22 jump suppressed
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, C, 0, 1, 0));  // 23 resume ignored
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 1, 0));  // 24
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, C, 0, 1, 0));  // 25 resume
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 26 RESUME
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 27
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, F, 0, 0, 0));  // 28 halt, no holds
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, P, 0, 0, 0));  // 29 DRAIN
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, C, 0, 1, 0));  // 30 HALTED after 2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 1, 0));  // 31
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, C, 0, 1, 0));  // 32 resume
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, C, 0, 0, 0));  // 33
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 34
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 0, P, 0, 0, 0));  // 35 -> DRAIN
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, P, 0, 0, 0));  // 36 halt drops -> RUN
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, P, 0, 0, 0));  // 37
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 38
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, C, 1, 0, 0));  // 39 jump
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, C, 0, 0, 0));  // 40 halt waits for flush
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, C, 0, 0, 0));  // 41
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, F, 0, 0, 0));  // 42 RUN -> DRAIN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, P, 0, 0, 0));  // 43 DRAIN, halt drops
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0));  // 44

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Watchdog: ten paused cycles, pulse only on the fifth when enabled.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      logic exp_to;
      exp_to = WdtOn && (i == 4);
      rst_n = 1'b1; jump = 1'b0; ex = 1'b1; rib = 1'b0; clint = 1'b0;
      halt = 1'b0; resume = 1'b0;
      #4;
      if (stall_timeout_o === 1'b1) pulses++;
      chk("wdt_hold", 100 + i, 32'(hold_flag_o), 32'(P));
      chk("wdt_timeout", 100 + i, 32'(stall_timeout_o), 32'(exp_to));
      @(posedge clk);
      #1;
    end
    chk("wdt_pulse_count", 110, pulses, WdtOn ? 1 : 0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0), 111);
    apply(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0), 112);

    // Reset during FLUSH.
    apply(mk(1, 1, 0, 0, 0, 0, 0, C, 1, 0, 0), 200);
    apply(mk(0, 0, 0, 0, 0, 0, 0, C, 0, 0, 0), 201);
    apply(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0), 202);
    apply(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0), 203);

    // Reset during HALTED.
    apply(mk(1, 0, 0, 0, 0, 1, 0, F, 0, 0, 0), 300);
    apply(mk(1, 0, 0, 0, 0, 1, 0, P, 0, 0, 0), 301);
    apply(mk(1, 0, 0, 0, 0, 1, 0, C, 0, 1, 0), 302);
    apply(mk(0, 0, 0, 0, 0, 1, 0, C, 0, 1, 0), 303);
    apply(mk(1, 0, 0, 0, 0, 0, 0, F, 0, 0, 0), 304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
